texture_lookup_arbiter: RTL

//  Shares one combinational (block_id, face) -> texture_id table among REQ_NUM requesters
//  (e.g. rasteriser lanes, minimap, HUD). Round-robin arbitration with valid/ready per requester.

---
 rtl/texture_lookup_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/texture_lookup_arbiter.sv
// Round-robin arbiter sharing one combinational texture table among requesters.
// One registered response stage carries tag, texture id and range-error flag.
module texture_lookup_arbiter #(
    parameter int BLOCK_NUM   = 16,
    parameter int FACE_NUM    = 6,
    parameter int TEXTURE_NUM = 20,
    parameter int REQ_NUM     = 4,
    localparam int BW = $clog2(BLOCK_NUM),
    localparam int FW = $clog2(FACE_NUM),
    localparam int TW = $clog2(TEXTURE_NUM),
    localparam int RW = $clog2(REQ_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REQ_NUM-1:0]    req_valid,
    output logic [REQ_NUM-1:0]    req_ready,
    input  logic [REQ_NUM*BW-1:0] req_block_id,
    input  logic [REQ_NUM*FW-1:0] req_face,
    output logic [BW-1:0]         lut_block_id,
    output logic [FW-1:0]         lut_face,
    input  logic [TW-1:0]         lut_texture_id,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [RW-1:0]         rsp_tag,
    output logic [TW-1:0]         rsp_texture_id,
    output logic                  rsp_err
);

    logic [RW-1:0] rr_ptr;
    logic [RW-1:0] winner;
    logic [RW-1:0] next_ptr;
    logic          any_valid;
    logic          can_accept;
    logic          transfer;
    logic          out_of_range;

    // Scan from rr_ptr upward (mod REQ_NUM); the nearest valid requester wins.
    // Iterating farthest-first lets the nearest hit overwrite earlier ones.
    always_comb begin
        any_valid = 1'b0;
        winner    = rr_ptr;
        for (int k = REQ_NUM - 1; k >= 0; k--) begin
            int j;
            j = (int'(rr_ptr) + k) % REQ_NUM;
            if (req_valid[j]) begin
                any_valid = 1'b1;
                winner    = RW'(j);
            end
        end
    end

    assign can_accept = !rsp_valid || rsp_ready;
    assign transfer   = can_accept && any_valid;

    // Grant is one-hot on the winner, only when the response slot can take it.
    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Table address follows the winner only; independent of rsp_ready.
    always_comb begin
        lut_block_id = req_block_id[winner*BW +: BW];
        lut_face     = req_face[winner*FW +: FW];
    end

    assign out_of_range = (32'(lut_block_id) >= BLOCK_NUM) ||
                          (32'(lut_face) >= FACE_NUM);

    assign next_ptr = (32'(winner) == REQ_NUM - 1) ? '0 : winner + 1'b1;

    // Round-robin pointer advances past each granted requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (transfer) begin
            rr_ptr <= next_ptr;
        end
    end

    // Response register: load on accept, drain on consume, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid      <= 1'b0;
            rsp_tag        <= '0;
            rsp_texture_id <= '0;
            rsp_err        <= 1'b0;
        end else if (transfer) begin
            rsp_valid <= 1'b1;
            rsp_tag   <= winner;
            if (out_of_range) begin
                rsp_texture_id <= '0;
                rsp_err        <= 1'b1;
            end else begin
                rsp_texture_id <= lut_texture_id;
                rsp_err        <= 1'b0;
            end
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule
